// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and sizing helper for the reset sequencer.
package reset_sequencer_pkg;

  // Two-bit sequencer state; the unused code 3 behaves as HOLD.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Bits needed to count from 0 up to max_val inclusive (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability debouncer.
module sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned CYCLES = 65535
) (
  input  logic clk,
  input  logic n_reset,
  input  logic enable,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = cnt_width(CYCLES);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounced level flips after CYCLES consecutive enabled cycles of disagreement.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (enable) begin
      if (s2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser flops run every cycle; debounce state follows enable.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/reset_sequencer.sv
// Merges reset causes and releases NUM_STAGES reset domains in order.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES       = 3,
  parameter int unsigned RESET_CYCLES     = 131071,
  parameter int unsigned STAGE_GAP        = 1024,
  parameter int unsigned DEBOUNCE_CYCLES  = 65535,
  parameter int unsigned LONGPRESS_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic                  pll_locked,
  input  logic                  button,
  input  logic                  soft_reset,
  output logic [NUM_STAGES-1:0] stage_nreset,
  output logic                  busy,
  output logic                  long_press,
  output logic                  button_db
);

  localparam int unsigned HOLD_W = cnt_width(RESET_CYCLES);
  localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);
  localparam int unsigned LP_W   = cnt_width(LONGPRESS_CYCLES);
  localparam int unsigned IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0] stage_nreset_q, stage_nreset_d;
  logic                  busy_q, busy_d;
  logic [LP_W-1:0]       lp_cnt_q, lp_cnt_d;
  logic                  long_press_q, long_press_d;
  logic                  locked_s1_q, locked_s_q;
  logic                  load_mask;
  logic                  fault_c;

  // Button conditioning.
  sync_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_button_db (
    .clk     (clk),
    .n_reset (n_reset),
    .enable  (enable),
    .din     (button),
    .dout    (button_db)
  );

  // Any active reset cause.
  assign fault_c = ~locked_s_q | button_db | soft_reset;

  // Sequencer next state: a fault always wins and is not gated by enable.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    stage_idx_d    = stage_idx_q;
    stage_nreset_d = stage_nreset_q;
    busy_d         = busy_q;
    load_mask      = 1'b0;

    case (state_q)
      ST_RELEASE, ST_RUN: begin
        if (fault_c) begin
          state_d        = ST_HOLD;
          hold_cnt_d     = '0;
          gap_cnt_d      = '0;
          stage_idx_d    = '0;
          stage_nreset_d = '0;
          busy_d         = 1'b1;
        end else if (state_q == ST_RELEASE && enable) begin
          if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
            gap_cnt_d   = '0;
            stage_idx_d = stage_idx_q + IDX_W'(1);
            load_mask   = 1'b1;
            if (stage_idx_d == IDX_W'(NUM_STAGES - 1)) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      default: begin
        stage_nreset_d = '0;
        busy_d         = 1'b1;
        gap_cnt_d      = '0;
        stage_idx_d    = '0;
        if (state_q != ST_HOLD) begin
          state_d = ST_HOLD;
        end
        if (fault_c) begin
          hold_cnt_d = '0;
        end else if (enable) begin
          if (hold_cnt_q == HOLD_W'(RESET_CYCLES)) begin
            hold_cnt_d = '0;
            load_mask  = 1'b1;
            if (NUM_STAGES == 1) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
    endcase

    if (load_mask) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_nreset_d[i] = (IDX_W'(i) <= stage_idx_d);
      end
    end
  end

  // Long-press counter saturates so the pulse fires once per press.
  always_comb begin
    lp_cnt_d     = lp_cnt_q;
    long_press_d = 1'b0;
    if (!button_db) begin
      lp_cnt_d = '0;
    end else if (enable && (lp_cnt_q != LP_W'(LONGPRESS_CYCLES))) begin
      lp_cnt_d = lp_cnt_q + LP_W'(1);
      if (lp_cnt_q == LP_W'(LONGPRESS_CYCLES - 1)) begin
        long_press_d = 1'b1;
      end
    end
  end

  // State, counters, PLL synchroniser and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      stage_idx_q    <= '0;
      stage_nreset_q <= '0;
      busy_q         <= 1'b1;
      lp_cnt_q       <= '0;
      long_press_q   <= 1'b0;
      locked_s1_q    <= 1'b0;
      locked_s_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      stage_idx_q    <= stage_idx_d;
      stage_nreset_q <= stage_nreset_d;
      busy_q         <= busy_d;
      lp_cnt_q       <= lp_cnt_d;
      long_press_q   <= long_press_d;
      locked_s1_q    <= pll_locked;
      locked_s_q     <= locked_s1_q;
    end
  end

  assign stage_nreset = stage_nreset_q;
  assign busy         = busy_q;
  assign long_press   = long_press_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer; cycle numbers count edges after n_reset release.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       enable;
  logic       pll_locked;
  logic       button;
  logic       soft_reset;
  logic [2:0] stage_nreset;
  logic       busy;
  logic       long_press;
  logic       button_db;

  int cyc;
  int checks;
  int failures;
  int pulses;
  int pulse_cyc;

  reset_sequencer #(
    .NUM_STAGES       (3),
    .RESET_CYCLES     (16),
    .STAGE_GAP        (4),
    .DEBOUNCE_CYCLES  (8),
    .LONGPRESS_CYCLES (64)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .enable       (enable),
    .pll_locked   (pll_locked),
    .button       (button),
    .soft_reset   (soft_reset),
    .stage_nreset (stage_nreset),
    .busy         (busy),
    .long_press   (long_press),
    .button_db    (button_db)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_stage(input string tag, input logic [2:0] exp_stage, input logic exp_busy);
    check({tag, "_stage"}, 32'(stage_nreset), 32'(exp_stage));
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    n_reset    = 1'b0;
    enable     = 1'b1;
    pll_locked = 1'b0;
    button     = 1'b0;
    soft_reset = 1'b0;

    // Reset values
    tick();
    tick();
    check_stage("reset", 3'b000, 1'b1);
    check("reset_lp", 32'(long_press), 32'd0);
    check("reset_db", 32'(button_db), 32'd0);
    n_reset = 1'b1;
    cyc     = 0;

    // 1. Power-up sequence
    run_to(10);
    pll_locked = 1'b1;
    run_to(28); check_stage("pu28", 3'b000, 1'b1);
    run_to(29); check_stage("pu29", 3'b001, 1'b1);
    run_to(32); check_stage("pu32", 3'b001, 1'b1);
    run_to(33); check_stage("pu33", 3'b011, 1'b1);
    run_to(36); check_stage("pu36", 3'b011, 1'b1);
    run_to(37); check_stage("pu37", 3'b111, 1'b0);

    // 2. Bounce is filtered, then a steady press debounces and faults
    run_to(40);
    for (int k = 0; k < 10; k++) begin
      button = ~button;
      tick(); tick(); tick();
      check("bounce_db", 32'(button_db), 32'd0);
      check("bounce_stage", 32'(stage_nreset), 32'(3'b111));
    end
    button = 1'b1;
    run_to(79); check("db79", 32'(button_db), 32'd0);
    run_to(80); check("db80", 32'(button_db), 32'd1);
    check_stage("db80", 3'b111, 1'b0);
    run_to(81); check_stage("db81", 3'b000, 1'b1);

    // 3. Long press: exactly one pulse, 64 cycles after button_db rose
    pulses    = 0;
    pulse_cyc = -1;
    while (cyc < 170) begin
      tick();
      if (long_press) begin
        pulses++;
        pulse_cyc = cyc;
      end
    end
    check("lp_count", 32'(pulses), 32'd1);
    check("lp_cycle", 32'(pulse_cyc), 32'd144);
    check_stage("lp170", 3'b000, 1'b1);
    button = 1'b0;
    run_to(179); check("dbfall179", 32'(button_db), 32'd1);
    run_to(180); check("dbfall180", 32'(button_db), 32'd0);
    run_to(196); check_stage("rs196", 3'b000, 1'b1);
    run_to(197); check_stage("rs197", 3'b001, 1'b1);
    run_to(201); check_stage("rs201", 3'b011, 1'b1);
    run_to(205); check_stage("rs205", 3'b111, 1'b0);

    // 4. soft_reset in RUN
    run_to(210);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check_stage("sr211", 3'b000, 1'b1);
    run_to(227); check_stage("sr227", 3'b000, 1'b1);
    run_to(228); check_stage("sr228", 3'b001, 1'b1);
    run_to(232); check_stage("sr232", 3'b011, 1'b1);
    run_to(236); check_stage("sr236", 3'b111, 1'b0);

    // 5. PLL loss coincides with final release: fault wins
    run_to(240);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check_stage("pl241", 3'b000, 1'b1);
    run_to(258); check_stage("pl258", 3'b001, 1'b1);
    run_to(262); check_stage("pl262", 3'b011, 1'b1);
    run_to(263);
    pll_locked = 1'b0;
    run_to(265); check_stage("pl265", 3'b011, 1'b1);
    run_to(266); check_stage("pl266", 3'b000, 1'b1);
    run_to(270); check_stage("pl270", 3'b000, 1'b1);
    pll_locked = 1'b1;
    run_to(288); check_stage("pl288", 3'b000, 1'b1);
    run_to(289); check_stage("pl289", 3'b001, 1'b1);

    // 6. enable=0 stretches the gap; a fault with enable=0 still asserts reset
    run_to(290);
    enable = 1'b0;
    run_to(300); check_stage("en300", 3'b001, 1'b1);
    enable = 1'b1;
    run_to(302); check_stage("en302", 3'b001, 1'b1);
    run_to(303); check_stage("en303", 3'b011, 1'b1);
    run_to(306); check_stage("en306", 3'b011, 1'b1);
    run_to(307); check_stage("en307", 3'b111, 1'b0);
    run_to(310);
    enable     = 1'b0;
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check_stage("ef311", 3'b000, 1'b1);
    run_to(320); check_stage("ef320", 3'b000, 1'b1);
    enable = 1'b1;
    run_to(336); check_stage("ef336", 3'b000, 1'b1);
    run_to(337); check_stage("ef337", 3'b001, 1'b1);

    // Asynchronous reset mid-sequence
    run_to(338);
    #2;
    n_reset = 1'b0;
    #1;
    check_stage("async", 3'b000, 1'b1);
    check("async_db", 32'(button_db), 32'd0);
    check("async_lp", 32'(long_press), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
